// File: rtl/vga_line_prefetch_pkg.sv
// Shared types and default timing constants for the vga line prefetch buffer.
// Holds the prefetch state enum and the RGB pixel layout.
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } pf_state_e;

    function automatic rgb_t to_rgb(input logic [23:0] word);
        return rgb_t'(word);
    endfunction

endpackage

// File: rtl/vga_line_prefetch_if.sv
// Renderer-to-buffer pixel stream: valid/ready handshake with a start-of-frame marker.
interface vga_line_prefetch_if #(
    parameter int PIX_W = 24
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic             pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/vga_line_prefetch_fifo.sv
// Single-clock FIFO with registered read data; a pop on empty returns zero.
// Occupancy is a dedicated counter so DEPTH entries can be distinguished from empty.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (pop) begin
                rd_data <= empty ? '0 : mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_line_prefetch.sv
// Elastic pixel buffer feeding the vga output stage; keeps renderer writes
// frame-aligned and flags underflow and wrong frame lengths.
module vga_line_prefetch #(
    parameter int PIX_W    = 24,
    parameter int DEPTH    = 1024,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_line_prefetch_if.slave     pix,
    input  logic                   i_frame_start,
    input  logic                   i_rd_en,
    output logic [PIX_W-1:0]       o_rd_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_underflow,
    output logic                   o_frame_err
);

    import vga_pkg::pf_state_e;
    import vga_pkg::SYNC;
    import vga_pkg::RUN;

    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int FRAME_LEN = H_ACTIVE * V_ACTIVE;
    localparam int WCW       = $clog2(FRAME_LEN + 1);
    localparam int XW        = $clog2(H_ACTIVE + 1);
    localparam int YW        = $clog2(V_ACTIVE + 1) + 1;

    localparam logic [WCW-1:0] WCNT_LAST = WCW'(FRAME_LEN - 1);
    localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);
    localparam logic [XW-1:0]  RX_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  RY_END    = YW'(V_ACTIVE);
    localparam logic [YW-1:0]  RY_MAX    = '1;

    pf_state_e       state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [XW-1:0]   rx_q, rx_d;
    logic [YW-1:0]   ry_q, ry_d;
    logic            underflow_d;
    logic            frame_err_d;
    logic            pix_ready;
    logic            push;
    logic            flush;
    logic            wr_err;
    logic            cnt_err;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;

    // Ready is forced low while reset is held so nothing is handshaken mid-reset.
    assign pix.pix_ready = pix_ready & ~rst;
    assign o_level       = fifo_level;

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pix.pix_data),
        .pop       (i_rd_en),
        .flush     (flush),
        .rd_data   (o_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            wcnt_q      <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            o_underflow <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            o_underflow <= underflow_d;
            o_frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        underflow_d = o_underflow;
        pix_ready   = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        wr_err      = 1'b0;
        cnt_err     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            SYNC: begin
                pix_ready = 1'b1;
                if (pix.pix_valid && pix.pix_sof) begin
                    push    = 1'b1;
                    wcnt_d  = WCNT_ONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                pix_ready = ~fifo_full;
                if (pix.pix_valid && !fifo_full) begin
                    push = 1'b1;
                    if (pix.pix_sof) begin
                        wr_err = (wcnt_q != '0);
                        wcnt_d = WCNT_ONE;
                    end else begin
                        wr_err = (wcnt_q == '0);
                        wcnt_d = (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // Reads are counted before any frame-start clear so a read on the same
        // cycle as the pulse still belongs to the frame that is ending.
        if (i_rd_en) begin
            if (fifo_empty) begin
                underflow_d = 1'b1;
            end
            if (rx_q == RX_LAST) begin
                rx_d = '0;
                ry_d = (ry_q == RY_MAX) ? ry_q : ry_q + 1'b1;
            end else begin
                rx_d = rx_q + 1'b1;
            end
        end

        if (i_frame_start) begin
            cnt_err = !((rx_d == '0) && (ry_d == RY_END));
            rx_d    = '0;
            ry_d    = '0;
            if (underflow_d) begin
                flush   = 1'b1;
                wcnt_d  = '0;
                state_d = SYNC;
            end
            underflow_d = 1'b0;
        end

        frame_err_d = wr_err | cnt_err;
    end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed self-checking bench for vga_line_prefetch using a tiny 4x2 frame and 8-deep FIFO.
module tb_vga_line_prefetch;

    localparam int PIX_W = 24;
    localparam int DEPTH = 8;
    localparam int HA    = 4;
    localparam int VA    = 2;

    logic                   clk;
    logic                   rst;
    logic                   frame_start;
    logic                   rd_en;
    logic [PIX_W-1:0]       rd_data;
    logic [$clog2(DEPTH):0] level;
    logic                   underflow;
    logic                   frame_err;

    int vectorCount = 0;
    int missCount   = 0;

    vga_line_prefetch_if #(.PIX_W(PIX_W)) pix_bus ();

    vga_line_prefetch #(
        .PIX_W    (PIX_W),
        .DEPTH    (DEPTH),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix           (pix_bus.slave),
        .i_frame_start (frame_start),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_level       (level),
        .o_underflow   (underflow),
        .o_frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 ns after the edge for sampling.
    task automatic applyStimulus(input logic valid, input logic [PIX_W-1:0] data,
                                 input logic sof, input logic rd, input logic fs);
        pix_bus.pix_valid = valid;
        pix_bus.pix_data  = data;
        pix_bus.pix_sof   = sof;
        rd_en             = rd;
        frame_start       = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_data  = '0;
        pix_bus.pix_sof   = 1'b0;
        rd_en             = 1'b0;
        frame_start       = 1'b0;

        // Reset behaviour
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_ready_c1", pix_bus.pix_ready, 0);
        checkOutput("rst_level_c1", level, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_ready_c2", pix_bus.pix_ready, 0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_ready", pix_bus.pix_ready, 1);
        checkOutput("post_rst_level", level, 0);
        checkOutput("post_rst_rd_data", rd_data, 0);
        checkOutput("post_rst_underflow", underflow, 0);
        checkOutput("post_rst_frame_err", frame_err, 0);

        // SYNC drops non-SOF pixels
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 24'(i + 1), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("sync_drop_level", level, 0);
        applyStimulus(1'b1, 24'h112233, 1'b1, 1'b0, 1'b0);
        checkOutput("sync_sof_level", level, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("sync_first_read", rd_data, 24'h112233);
        checkOutput("sync_level_after_read", level, 0);

        // Fill to full
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 24'hA0 + 24'(i), (i == 0), 1'b0, 1'b0);
        end
        checkOutput("full_level", level, 8);
        checkOutput("full_ready", pix_bus.pix_ready, 0);
        applyStimulus(1'b1, 24'hA8, 1'b0, 1'b1, 1'b0);
        checkOutput("full_rd_head", rd_data, 24'hA0);
        checkOutput("full_no_writethrough", level, 7);
        applyStimulus(1'b1, 24'hA8, 1'b0, 1'b0, 1'b0);
        checkOutput("full_refill_level", level, 8);
        checkOutput("full_wrap_nonsof_err", frame_err, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("full_drain_%0d", i), rd_data, 24'hA1 + 24'(i));
        end
        checkOutput("full_drained_level", level, 0);

        // Underflow and recovery through frame start
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("uf_rd_black", rd_data, 0);
        checkOutput("uf_flag", underflow, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("uf_flag_sticky", underflow, 1);
        checkOutput("uf_write_level", level, 1);
        checkOutput("uf_rd_hold", rd_data, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("uf_fs_flush_level", level, 0);
        checkOutput("uf_fs_clear", underflow, 0);
        checkOutput("uf_fs_len_err", frame_err, 1);
        applyStimulus(1'b1, 24'h66, 1'b0, 1'b0, 1'b0);
        checkOutput("uf_sync_drop", level, 0);
        checkOutput("uf_err_pulse_end", frame_err, 0);
        applyStimulus(1'b1, 24'h77, 1'b1, 1'b0, 1'b0);
        checkOutput("uf_sync_sof", level, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("uf_resync_read", rd_data, 24'h77);

        // Frame length checks
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("len_8_ok", frame_err, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("len_8_read_with_fs", frame_err, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("len_7_err", frame_err, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("len_7_pulse_end", frame_err, 0);

        // SOF misalignment and realign
        doReset();
        applyStimulus(1'b1, 24'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h02, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h03, 1'b0, 1'b0, 1'b0);
        checkOutput("sof_pre_no_err", frame_err, 0);
        applyStimulus(1'b1, 24'hC0, 1'b1, 1'b0, 1'b0);
        checkOutput("sof_mis_err", frame_err, 1);
        checkOutput("sof_mis_stored", level, 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("sof_mis_pulse_end", frame_err, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("sof_read_%0d", i), rd_data,
                        (i == 3) ? 32'hC0 : 32'(i + 1));
        end
        applyStimulus(1'b1, 24'hC1, 1'b0, 1'b1, 1'b0);
        checkOutput("sof_empty_rw_level", level, 1);
        checkOutput("sof_empty_rw_black", rd_data, 0);
        checkOutput("sof_empty_rw_uf", underflow, 1);
        for (int i = 2; i < 8; i++) begin
            applyStimulus(1'b1, 24'hC0 + 24'(i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("sof_frame_px%0d", i), frame_err, 0);
        end
        checkOutput("sof_frame_level", level, 7);
        applyStimulus(1'b1, 24'hD0, 1'b1, 1'b0, 1'b0);
        checkOutput("sof_next_frame_ok", frame_err, 0);
        checkOutput("sof_next_level", level, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
